// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
// Sequencing and accumulation stage of the 8x8 sequential multiplier.
// Walks the four nibble pairs (A.lo*B.lo, A.lo*B.hi, A.hi*B.lo, A.hi*B.hi),
// drives the operand mux selects, and shifts/accumulates the 8-bit partial
// products from the external 4x4 multiplier into a 16-bit result.
//
// Ports:
//   clk      in   1  rising-edge clock
//   reset    in   1  asynchronous, active-high; clears all state
//   start    in   1  begin a multiplication (honoured in IDLE and DONE)
//   pp_in    in   8  partial product for the currently selected nibbles
//   sel_a    out  1  A mux select: 0 = A[3:0], 1 = A[7:4]
//   sel_b    out  1  B mux select: 0 = B[3:0], 1 = B[7:4]
//   busy     out  1  high in C0..C3
//   done     out  1  one-cycle completion pulse; product valid from here on
//   product  out 16  registered result, held until the next completion

module mult_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  pp_in,
    output logic        sel_a,
    output logic        sel_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_C0   = 3'd1,
        S_C1   = 3'd2,
        S_C2   = 3'd3,
        S_C3   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_acc;
    logic [15:0] r_product;

    // Zero-extend the partial product to 16 bits, then weight it.
    function automatic logic [15:0] f_shift(input logic [7:0] pp, input logic [3:0] sh);
        f_shift = {8'h00, pp} << sh;
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start is ignored while busy.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_C0 : S_IDLE;
            S_C0:    w_next = S_C1;
            S_C1:    w_next = S_C2;
            S_C2:    w_next = S_C3;
            S_C3:    w_next = S_DONE;
            S_DONE:  w_next = start ? S_C0 : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded purely from state so the mux selects never glitch.
    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (r_state)
            S_C0:   busy = 1'b1;
            S_C1: begin
                sel_b = 1'b1;
                busy  = 1'b1;
            end
            S_C2: begin
                sel_a = 1'b1;
                busy  = 1'b1;
            end
            S_C3: begin
                sel_a = 1'b1;
                sel_b = 1'b1;
                busy  = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Accumulator and result register. The final term is folded straight
    // into product so the result lands on the same edge that enters DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= 16'h0000;
            r_product <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (start) r_acc <= 16'h0000;
                S_C0:    r_acc     <= r_acc + f_shift(pp_in, 4'd0);
                S_C1:    r_acc     <= r_acc + f_shift(pp_in, 4'd4);
                S_C2:    r_acc     <= r_acc + f_shift(pp_in, 4'd4);
                S_C3:    r_product <= r_acc + f_shift(pp_in, 4'd8);
                default: ;
            endcase
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  pp_in;
    logic        sel_a;
    logic        sel_b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    logic [7:0]  op_a;
    logic [7:0]  op_b;

    int n_total;
    int n_bad;

    mult_seq_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pp_in   (pp_in),
        .sel_a   (sel_a),
        .sel_b   (sel_b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand muxes plus 4x4 multiplier feeding the block.
    logic [3:0] nib_a;
    logic [3:0] nib_b;
    always_comb begin
        nib_a = sel_a ? op_a[7:4] : op_a[3:0];
        nib_b = sel_b ? op_b[7:4] : op_b[3:0];
        pp_in = {4'h0, nib_a} * {4'h0, nib_b};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [15:0] exp_prod);
        chk({tag, ".ctl"}, {28'd0, sel_a, sel_b, busy, done}, 32'h0);
        chk({tag, ".prod"}, {16'd0, product}, {16'd0, exp_prod});
    endtask

    // One full run from IDLE; checks selects, busy, done timing and result.
    // pp_exp holds the expected pp_in per cycle C0..C3 (MSB byte first) when chk_pp=1.
    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                       input logic [15:0] prev, input bit chk_pp, input logic [31:0] pp_exp);
        logic [1:0] sel_exp [4];
        sel_exp[0] = 2'b00; sel_exp[1] = 2'b01; sel_exp[2] = 2'b10; sel_exp[3] = 2'b11;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("run%0h_%0h.c%0d.sel", a, b, c), {30'd0, sel_a, sel_b}, {30'd0, sel_exp[c]});
            chk($sformatf("run%0h_%0h.c%0d.busy", a, b, c), {30'd0, busy, done}, 32'h2);
            if (chk_pp)
                chk($sformatf("run%0h_%0h.c%0d.pp", a, b, c), {24'd0, pp_in}, {24'd0, pp_exp[31-8*c -: 8]});
            chk($sformatf("run%0h_%0h.c%0d.hold", a, b, c), {16'd0, product}, {16'd0, prev});
            step();
        end
        chk($sformatf("run%0h_%0h.done", a, b), {29'd0, busy, done, sel_a | sel_b}, 32'h2);
        chk($sformatf("run%0h_%0h.prod", a, b), {16'd0, product}, {16'd0, exp});
        step();
        chk_idle($sformatf("run%0h_%0h.after", a, b), exp);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        start   = 1'b0;
        op_a    = 8'h00;
        op_b    = 8'h00;
        #1;
        chk_idle("rst.async", 16'h0000);
        repeat (2) step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle($sformatf("idle%0d", i), 16'h0000);
        end

        // Directed single runs
        run(8'h12, 8'h34, 16'h03A8, 16'h0000, 1'b1, 32'h08060403);
        run(8'hFF, 8'hFF, 16'hFE01, 16'h03A8, 1'b0, 32'h0);
        run(8'h00, 8'hAB, 16'h0000, 16'hFE01, 1'b0, 32'h0);
        run(8'h80, 8'h02, 16'h0100, 16'h0000, 1'b0, 32'h0);

        // start held high: DONE -> C0 directly, result every 5 cycles
        op_a  = 8'h0F;
        op_b  = 8'h10;
        start = 1'b1;
        step();
        chk("b2b.c0.busy", {30'd0, busy, done}, 32'h2);
        for (int r = 0; r < 3; r++) begin
            step();
            step();
            chk($sformatf("b2b%0d.c2.sel", r), {30'd0, sel_a, sel_b}, 32'h2);
            step();
            chk($sformatf("b2b%0d.c3.prod", r), {16'd0, product}, (r == 0) ? 32'h0100 : 32'h00F0);
            step();
            chk($sformatf("b2b%0d.done", r), {30'd0, busy, done}, 32'h1);
            chk($sformatf("b2b%0d.prod", r), {16'd0, product}, 32'h00F0);
            step();
            chk($sformatf("b2b%0d.restart", r), {30'd0, busy, done}, 32'h2);
        end
        start = 1'b0;
        repeat (4) step();
        chk("b2b.last.done", {31'd0, done}, 32'h1);
        step();
        chk_idle("b2b.idle", 16'h00F0);

        // start pulsed during C1 must not queue another run
        op_a  = 8'h03;
        op_b  = 8'h21;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("c1pulse.sel", {30'd0, sel_a, sel_b}, 32'h1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("c1pulse.c2", {29'd0, sel_a, sel_b, busy}, 32'h5);
        step();
        step();
        chk("c1pulse.done", {30'd0, busy, done}, 32'h1);
        chk("c1pulse.prod", {16'd0, product}, 32'h0063);
        step();
        chk_idle("c1pulse.noreq", 16'h0063);

        // Asynchronous reset in the middle of C2
        op_a  = 8'h12;
        op_b  = 8'h34;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("midrst.inC2", {29'd0, sel_a, sel_b, busy}, 32'h5);
        #2;
        reset = 1'b1;
        #1;
        chk_idle("midrst.async", 16'h0000);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_idle($sformatf("midrst.nodone%0d", i), 16'h0000);
        end
        run(8'h05, 8'h07, 16'h0023, 16'h0000, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequencing and accumulation stage of the 8x8 sequential multiplier. It drives the nibble-select lines of the two 4-bit operand muxes, one for operand A and one for operand B. It consumes the 8-bit partial product that the 4x4 multiplier forms from the selected nibbles. It shifts and accumulates four partial products into a 16-bit result and reports completion with a one-cycle `done` pulse.

## Interface
- Parameters: none. Widths are fixed: 8x8 operands, 4-bit nibbles, 8-bit partial product, 16-bit result.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `start` input 1: request a new multiplication; sampled on the rising edge.
- `pp_in` input 8: partial product from the 4x4 multiplier for the nibbles currently selected.
- `sel_a` output 1: select for the A-operand mux; 0 = low nibble A[3:0], 1 = high nibble A[7:4].
- `sel_b` output 1: select for the B-operand mux; same encoding as `sel_a`.
- `busy` output 1: high while a multiplication is in progress (states C0–C3).
- `done` output 1: one-cycle pulse; `product` is valid from this cycle on.
- `product` output 16: registered result; holds its value until the next completion.

## Operation
- FSM states: IDLE, C0, C1, C2, C3, DONE. The state register is the only source of `sel_a`/`sel_b`/`busy`/`done`, which are decoded directly from the state with no combinational dependence on inputs.
- IDLE: `sel_a`=0, `sel_b`=0, `busy`=0, `done`=0.
  - `start`=1 → C0, accumulator cleared to 0.
  - Otherwise stay in IDLE.
- C0: `sel_a`=0, `sel_b`=0; accumulator += `pp_in` << 0 → C1.
- C1: `sel_a`=0, `sel_b`=1; accumulator += `pp_in` << 4 → C2.
- C2: `sel_a`=1, `sel_b`=0; accumulator += `pp_in` << 4 → C3.
- C3: `sel_a`=1, `sel_b`=1; `product` ← accumulator + (`pp_in` << 8) → DONE.
- DONE: `done`=1, `busy`=0, selects 0.
  - `start`=1 → C0, accumulator cleared. This is a back-to-back run; `product` stays unchanged until that run's C3.
  - Otherwise → IDLE.
- Arithmetic: the accumulator is 16 bits unsigned. Shifted terms are zero-extended to 16 bits. The maximum sum is 0xFE01, so no overflow is possible and no carry-out is kept.
- `start` asserted in C0–C3 is ignored. It is not queued.
- The operands on the mux inputs must be held stable by the upstream stage from the `start` edge through C3. This block does not capture operands.
- `pp_in` must be valid from the time it settles in each Cx cycle until the closing edge of that cycle.

## Timing
- Reset values: state=IDLE, accumulator=0, `product`=0x0000, `sel_a`=0, `sel_b`=0, `busy`=0, `done`=0.
- Reset asserted mid-operation (any of C0–C3 or DONE): the block goes to IDLE at once with the values above. No `done` pulse is produced and `product` is cleared to 0.
- Latency: `start` is sampled at edge E0.
  - C0–C3 occupy the cycles after edges E0–E3.
  - `done`=1 in the cycle after E4, and `product` is valid in that same cycle.
  - Start-to-done is 5 cycles.
- Throughput: with `start` held high, a new result is produced every 5 cycles (DONE → C0 directly).
- `busy` rises in the cycle after the `start` edge and falls in the DONE cycle.
- `done` is never high for two consecutive cycles.
- The selects change only on clock edges and are glitch-free, since they come from registered state.

## Test plan
The bench models the two operand muxes and the 4x4 multiplier, so `pp_in` = nibble(A, `sel_a`) × nibble(B, `sel_b`).
- Reset, then idle 3 cycles → all outputs 0, `product`=0x0000, selects 0.
- Single run with A=0x12, B=0x34:
  - `pp_in` per cycle: 0x08, 0x06, 0x04, 0x03.
  - Selects step 00, 01, 10, 11.
  - `done` pulses 5 cycles after `start`, with `product`=0x03A8.
- Corner operands:
  - A=0xFF, B=0xFF → `product`=0xFE01.
  - A=0x00, B=0xAB → `product`=0x0000.
  - A=0x80, B=0x02 → `product`=0x0100.
- `start` held high continuously with A=0x0F, B=0x10:
  - `done` pulses every 5 cycles, each with `product`=0x00F0.
  - Pulsing `start` in C1 has no effect.
- Reset asserted between clock edges during C2:
  - Outputs go to reset values before the next edge.
  - No `done` pulse follows.
  - A following run with A=0x05, B=0x07 yields 0x0023.
